// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store alignment unit.
//   state_t      : FSM states of lsu_align_unit
//   F3_*         : RV32 load/store funct3 encodings
//   size_bytes   : access size in bytes for a funct3
//   funct3_legal : whether a funct3 is a legal load or store encoding
// ----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    REQ2,
    WAIT2,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] encodes the size for both signed and unsigned variants.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    if (is_store) begin
      return funct3 inside {F3_B, F3_H, F3_W};
    end
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// ----------------------------------------------------------------------------
// lsu_load_extend
// Combinational load-data extractor: shifts the addressed bytes of a memory
// word down to lane 0, truncates to the access size and sign- or zero-extends.
// Ports:
//   rdata  in  XLEN  word read from memory (or merged split-access window)
//   offset in  2     byte offset of the access within rdata
//   funct3 in  3     load type (b, h, w, bu, hu)
//   data   out XLEN  extended load result
// ----------------------------------------------------------------------------
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (funct3)
      F3_B:    data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_H:    data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_align_unit.sv
// ----------------------------------------------------------------------------
// lsu_align_unit
// Load/store alignment unit between the execute stage and a word-wide data
// memory. Accepts one RV32 load/store per handshake, issues word-aligned
// memory requests with byte enables, lane-shifts store data and extends load
// data. Illegal funct3 values fault without touching memory.
//
// Optional feature (compile-time macro LSU_MISALIGN_SPLIT_EN):
//   undefined : misaligned h/w accesses fault without touching memory.
//   defined   : word-crossing accesses are split into two beats (REQ2/WAIT2);
//               load bytes from both beats are merged before extension.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             pipeline request handshake
//   req_is_store, req_funct3        access type
//   req_addr, req_wdata             byte address, right-justified store data
//   mem_req_valid/mem_req_ready     memory request handshake
//   mem_we, mem_addr, mem_be        write enable, word address, byte enables
//   mem_wdata                       lane-shifted store data
//   mem_rsp_valid, mem_rdata        load read data return
//   rsp_valid/rsp_ready             result handshake to the pipeline
//   rsp_rdata, rsp_fault            extended load data, fault flag
// ----------------------------------------------------------------------------
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault
);

  localparam int NB = XLEN / 8;

  state_t            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              split_q, split_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [NB-1:0]     be_hi_q, be_hi_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]   wdata_hi_q, wdata_hi_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   beat0_q, beat0_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;

  logic [1:0]        req_off;
  logic [2:0]        req_size;
  logic [NB-1:0]     req_mask;
  logic [2*NB-1:0]   req_be_wide;
  logic [2*XLEN-1:0] req_wdata_wide;
  logic              req_fault;
  logic              req_split;

  logic [XLEN-1:0]   ext_rdata;
  logic [1:0]        ext_offset;
  logic [5:0]        merge_shift;
  logic [XLEN-1:0]   ext_data;

  // Request decode. Byte enables and store data are shifted into a
  // double-width window: the low half is the first (or only) beat, the high
  // half is what spills into the next word on a crossing access.
  always_comb begin
    req_off  = req_addr[1:0];
    req_size = size_bytes(req_funct3);
    case (req_size)
      3'd1:    req_mask = NB'(1);
      3'd2:    req_mask = NB'(3);
      default: req_mask = '1;
    endcase
    req_be_wide    = {{NB{1'b0}}, req_mask} << req_off;
    req_wdata_wide = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
    req_fault = !funct3_legal(req_is_store, req_funct3);
    req_split = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;
`else
    req_fault = !funct3_legal(req_is_store, req_funct3)
              || ((req_size == 3'd2) && req_off[0])
              || ((req_size == 3'd4) && (req_off != 2'b00));
    req_split = 1'b0;
`endif
  end

  // For the second beat of a split load the bytes are merged into one
  // right-justified window, so the extender sees offset 0. A split access
  // always has a non-zero offset, hence merge_shift is always below XLEN.
  always_comb begin
    merge_shift = 6'(XLEN) - {1'b0, off_q, 3'b000};
    ext_rdata   = mem_rdata;
    ext_offset  = off_q;
    if (state_q == WAIT2) begin
      ext_rdata  = (beat0_q >> {off_q, 3'b000}) | (mem_rdata << merge_shift);
      ext_offset = 2'b00;
    end
  end

  lsu_load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .rdata (ext_rdata),
    .offset(ext_offset),
    .funct3(funct3_q),
    .data  (ext_data)
  );

  // Next-state logic. All memory request fields are registered so they stay
  // stable while mem_req_valid waits for mem_req_ready.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    split_d     = split_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    be_hi_d     = be_hi_q;
    mem_wdata_d = mem_wdata_q;
    wdata_hi_d  = wdata_hi_q;
    mem_we_d    = mem_we_q;
    beat0_d     = beat0_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          off_d      = req_off;
          if (req_fault) begin
            state_d     = RESP;
            rsp_fault_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = REQ;
            split_d     = req_split;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = req_be_wide[NB-1:0];
            be_hi_d     = req_be_wide[2*NB-1:NB];
            mem_wdata_d = req_wdata_wide[XLEN-1:0];
            wdata_hi_d  = req_wdata_wide[2*XLEN-1:XLEN];
            mem_we_d    = req_is_store;
            rsp_fault_d = 1'b0;
          end
        end
      end

      REQ: begin
        if (mem_req_ready) begin
          if (!is_store_q) begin
            state_d = WAIT;
          end else if (split_q) begin
            state_d     = REQ2;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_be_d    = be_hi_q;
            mem_wdata_d = wdata_hi_q;
          end else begin
            state_d     = RESP;
            rsp_rdata_d = '0;
          end
        end
      end

      WAIT: begin
        if (mem_rsp_valid) begin
          if (split_q) begin
            state_d     = REQ2;
            beat0_d     = mem_rdata;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_be_d    = be_hi_q;
            mem_wdata_d = wdata_hi_q;
          end else begin
            state_d     = RESP;
            rsp_rdata_d = ext_data;
          end
        end
      end

      REQ2: begin
        if (mem_req_ready) begin
          if (is_store_q) begin
            state_d     = RESP;
            rsp_rdata_d = '0;
          end else begin
            state_d = WAIT2;
          end
        end
      end

      WAIT2: begin
        if (mem_rsp_valid) begin
          state_d     = RESP;
          rsp_rdata_d = ext_data;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      split_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      be_hi_q     <= '0;
      mem_wdata_q <= '0;
      wdata_hi_q  <= '0;
      mem_we_q    <= 1'b0;
      beat0_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      split_q     <= split_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      be_hi_q     <= be_hi_d;
      mem_wdata_q <= mem_wdata_d;
      wdata_hi_q  <= wdata_hi_d;
      mem_we_q    <= mem_we_d;
      beat0_q     <= beat0_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ) || (state_q == REQ2);
  assign rsp_valid     = (state_q == RESP);
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_fault     = rsp_fault_q;

endmodule

// File: tb/tb_lsu_align_unit.sv
// ----------------------------------------------------------------------------
// tb_lsu_align_unit
// Directed self-checking bench for lsu_align_unit. Covers aligned loads and
// stores, sign/zero extension, illegal funct3, misaligned handling (fault by
// default, two-beat split when LSU_MISALIGN_SPLIT_EN is defined), memory and
// response back-pressure, and asynchronous reset mid-transaction.
// ----------------------------------------------------------------------------
module tb_lsu_align_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int memReqCycles = 0;

  lsu_align_unit #(
    .XLEN  (32),
    .ADDR_W(32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter for latency measurement and a count of cycles in which a
  // memory request was visible, used to prove faulting accesses stay off the bus.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req_valid) memReqCycles <= memReqCycles + 1;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Compares every output against its reset value.
  task automatic checkReset(input string tag);
    checkOutput({tag, "_reqReady"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_memReqValid"}, 32'(mem_req_valid), 32'd0);
    checkOutput({tag, "_memWe"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_memAddr"}, mem_addr, 32'd0);
    checkOutput({tag, "_memBe"}, 32'(mem_be), 32'd0);
    checkOutput({tag, "_memWdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_rspValid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rspRdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, "_rspFault"}, 32'(rsp_fault), 32'd0);
  endtask

  // Presents one request from a negedge; returns just after the accepting edge.
  task automatic applyStimulus(input logic isStore, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output int accCyc);
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = isStore;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    accCyc       = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("reqReadyBusy", 32'(req_ready), 32'd0);
  endtask

  // Plays the memory for one beat: checks the request, optionally stalls it,
  // accepts it and, for loads, returns read data one cycle later.
  task automatic serveBeat(input string tag, input logic [31:0] expAddr, input logic [3:0] expBe,
                           input logic expWe, input logic [31:0] expWdata, input int stall,
                           input logic isLoad, input logic [31:0] rdata);
    int n;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!mem_req_valid) begin
      checkOutput({tag, "_memTimeout"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, "_addr"}, mem_addr, expAddr);
    checkOutput({tag, "_be"}, 32'(mem_be), 32'(expBe));
    checkOutput({tag, "_we"}, 32'(mem_we), 32'(expWe));
    if (expWe) checkOutput({tag, "_wdata"}, mem_wdata, expWdata);
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk);
        #1;
      end
      checkOutput({tag, "_holdValid"}, 32'(mem_req_valid), 32'd1);
      checkOutput({tag, "_holdAddr"}, mem_addr, expAddr);
      checkOutput({tag, "_holdBe"}, 32'(mem_be), 32'(expBe));
      checkOutput({tag, "_holdWdata"}, mem_wdata, expWe ? expWdata : mem_wdata);
    end
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    if (isLoad) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = rdata;
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      mem_rdata     = '0;
    end
  endtask

  // Waits for the result, checks it, optionally holds rsp_ready low, then consumes it.
  task automatic collectResp(input string tag, input logic [31:0] expData, input logic expFault,
                             input int stall, output int rspCyc);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    rspCyc = cyc;
    if (!rsp_valid) begin
      checkOutput({tag, "_rspTimeout"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, "_rdata"}, rsp_rdata, expData);
    checkOutput({tag, "_fault"}, 32'(rsp_fault), 32'(expFault));
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk);
        #1;
      end
      checkOutput({tag, "_holdRspValid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, "_holdRdata"}, rsp_rdata, expData);
      checkOutput({tag, "_holdFault"}, 32'(rsp_fault), 32'(expFault));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    int acc;
    int rsp;
    int m0;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned word load and minimum latency.
    applyStimulus(1'b0, F3_W, 32'h0000_0100, 32'h0, acc);
    serveBeat("lw", 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 0, 1'b1, 32'h8765_4321);
    collectResp("lw", 32'h8765_4321, 1'b0, 0, rsp);
    checkOutput("lwLatency", 32'(rsp - acc), 32'd3);

    // Byte and halfword loads with sign and zero extension.
    applyStimulus(1'b0, F3_B, 32'h0000_0103, 32'h0, acc);
    serveBeat("lb3", 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 0, 1'b1, 32'h8012_3456);
    collectResp("lb3", 32'hFFFF_FF80, 1'b0, 0, rsp);

    applyStimulus(1'b0, F3_BU, 32'h0000_0103, 32'h0, acc);
    serveBeat("lbu3", 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 0, 1'b1, 32'h8012_3456);
    collectResp("lbu3", 32'h0000_0080, 1'b0, 0, rsp);

    applyStimulus(1'b0, F3_B, 32'h0000_0101, 32'h0, acc);
    serveBeat("lb1", 32'h0000_0100, 4'b0010, 1'b0, 32'h0, 0, 1'b1, 32'h1234_7F56);
    collectResp("lb1", 32'h0000_007F, 1'b0, 0, rsp);

    applyStimulus(1'b0, F3_H, 32'h0000_0102, 32'h0, acc);
    serveBeat("lh2", 32'h0000_0100, 4'b1100, 1'b0, 32'h0, 0, 1'b1, 32'h9ABC_1234);
    collectResp("lh2", 32'hFFFF_9ABC, 1'b0, 0, rsp);

    // Halfword unsigned with the pipeline stalling the response for 3 cycles.
    applyStimulus(1'b0, F3_HU, 32'h0000_0102, 32'h0, acc);
    serveBeat("lhu2", 32'h0000_0100, 4'b1100, 1'b0, 32'h0, 0, 1'b1, 32'h9ABC_1234);
    collectResp("lhu2", 32'h0000_9ABC, 1'b0, 3, rsp);

    // Stores: lane shifting and byte enables.
    applyStimulus(1'b1, F3_H, 32'h0000_0102, 32'h0000_BEEF, acc);
    serveBeat("sh2", 32'h0000_0100, 4'b1100, 1'b1, 32'hBEEF_0000, 0, 1'b0, 32'h0);
    collectResp("sh2", 32'h0, 1'b0, 0, rsp);

    applyStimulus(1'b1, F3_B, 32'h0000_0201, 32'h0000_00AB, acc);
    serveBeat("sb1", 32'h0000_0200, 4'b0010, 1'b1, 32'h0000_AB00, 0, 1'b0, 32'h0);
    collectResp("sb1", 32'h0, 1'b0, 0, rsp);

    // Store with memory back-pressure for 5 cycles and response stall for 3.
    applyStimulus(1'b1, F3_W, 32'h0000_0200, 32'hCAFE_F00D, acc);
    serveBeat("swStall", 32'h0000_0200, 4'b1111, 1'b1, 32'hCAFE_F00D, 5, 1'b0, 32'h0);
    collectResp("swStall", 32'h0, 1'b0, 3, rsp);

    // Illegal funct3: fault without any memory traffic.
    m0 = memReqCycles;
    applyStimulus(1'b0, 3'b011, 32'h0000_0100, 32'h0, acc);
    collectResp("ld011", 32'h0, 1'b1, 0, rsp);
    applyStimulus(1'b1, 3'b100, 32'h0000_0100, 32'h1234_5678, acc);
    collectResp("st100", 32'h0, 1'b1, 0, rsp);
    checkOutput("illegalNoMem", 32'(memReqCycles - m0), 32'd0);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Word-crossing load split over two beats.
    applyStimulus(1'b0, F3_W, 32'h0000_0101, 32'h0, acc);
    serveBeat("lwSplit0", 32'h0000_0100, 4'b1110, 1'b0, 32'h0, 0, 1'b1, 32'h4433_2211);
    serveBeat("lwSplit1", 32'h0000_0104, 4'b0001, 1'b0, 32'h0, 0, 1'b1, 32'h8877_6655);
    collectResp("lwSplit", 32'h5544_3322, 1'b0, 0, rsp);

    // Misaligned but within one word: single beat, no fault.
    applyStimulus(1'b0, F3_H, 32'h0000_0101, 32'h0, acc);
    serveBeat("lhIn", 32'h0000_0100, 4'b0110, 1'b0, 32'h0, 0, 1'b1, 32'h00C0_FF00);
    collectResp("lhIn", 32'hFFFF_C0FF, 1'b0, 0, rsp);

    // Word-crossing store.
    applyStimulus(1'b1, F3_W, 32'h0000_0103, 32'h1122_3344, acc);
    serveBeat("swSplit0", 32'h0000_0100, 4'b1000, 1'b1, 32'h4400_0000, 0, 1'b0, 32'h0);
    serveBeat("swSplit1", 32'h0000_0104, 4'b0111, 1'b1, 32'h0011_2233, 0, 1'b0, 32'h0);
    collectResp("swSplit", 32'h0, 1'b0, 0, rsp);

    // Second beat address wraps around the top of the address space.
    applyStimulus(1'b0, F3_H, 32'hFFFF_FFFF, 32'h0, acc);
    serveBeat("lhWrap0", 32'hFFFF_FFFC, 4'b1000, 1'b0, 32'h0, 0, 1'b1, 32'hAA00_0000);
    serveBeat("lhWrap1", 32'h0000_0000, 4'b0001, 1'b0, 32'h0, 0, 1'b1, 32'h0000_00BB);
    collectResp("lhWrap", 32'hFFFF_BBAA, 1'b0, 0, rsp);
`else
    // Misaligned accesses fault without memory traffic.
    m0 = memReqCycles;
    applyStimulus(1'b0, F3_W, 32'h0000_0101, 32'h0, acc);
    collectResp("lwMis", 32'h0, 1'b1, 0, rsp);
    applyStimulus(1'b0, F3_H, 32'h0000_0101, 32'h0, acc);
    collectResp("lhMis", 32'h0, 1'b1, 0, rsp);
    applyStimulus(1'b1, F3_W, 32'h0000_0102, 32'hDEAD_BEEF, acc);
    collectResp("swMis", 32'h0, 1'b1, 0, rsp);
    checkOutput("misNoMem", 32'(memReqCycles - m0), 32'd0);
`endif

    // Asynchronous reset while waiting for load data; a late response is ignored.
    applyStimulus(1'b0, F3_W, 32'h0000_0300, 32'h0, acc);
    checkOutput("rstWait_req", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    checkOutput("rstWait_inWait", 32'(mem_req_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkReset("rstWait");
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1357_9BDF;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    @(posedge clk);
    #1;
    checkOutput("lateRsp_rspValid", 32'(rsp_valid), 32'd0);
    checkOutput("lateRsp_reqReady", 32'(req_ready), 32'd1);

    // Asynchronous reset while a memory request is pending drops it at once.
    applyStimulus(1'b1, F3_W, 32'h0000_0400, 32'h0BAD_F00D, acc);
    checkOutput("rstReq_valid", 32'(mem_req_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkReset("rstReq");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal operation after reset.
    applyStimulus(1'b0, F3_BU, 32'h0000_0102, 32'h0, acc);
    serveBeat("lbuPost", 32'h0000_0100, 4'b0100, 1'b0, 32'h0, 0, 1'b1, 32'h0055_0000);
    collectResp("lbuPost", 32'h0000_0055, 1'b0, 0, rsp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
